// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants and state type for the display scheduler
package seg_pkg;

    localparam logic [3:0]  SEG_C     = 4'd10;
    localparam logic [3:0]  SEG_DASH  = 4'd11;
    localparam logic [3:0]  SEG_OFF   = 4'd15;
    localparam logic [15:0] SEG_BLANK = {4{SEG_OFF}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        ALERT = 2'd2
    } seg_state_t;

endpackage

// File: rtl/seg_rr_pick.sv
// rtl/seg_rr_pick.sv - combinational round-robin finder: first valid index after i_cur, wrapping
module seg_rr_pick #(
    parameter int NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0] i_valid,
    input  logic [2:0]         i_cur,
    output logic [2:0]         o_next,
    output logic               o_any_valid
);

    int w_off;
    int w_best;

    // Distance from i_cur; the current index itself ranks last so a lone source is kept.
    always_comb begin
        o_next      = i_cur;
        o_any_valid = |i_valid;
        w_best      = NUM_SRC + 1;
        w_off       = 0;
        for (int j = 0; j < NUM_SRC; j++) begin
            if (i_valid[j]) begin
                w_off = (j - int'(i_cur) + 8 * NUM_SRC) % NUM_SRC;
                if (w_off == 0) begin
                    w_off = NUM_SRC;
                end
                if (w_off < w_best) begin
                    w_best = w_off;
                    o_next = 3'(j);
                end
            end
        end
    end

endmodule

// File: rtl/seg_display_scheduler.sv
// rtl/seg_display_scheduler.sv - round-robin 7-segment display sharing with alert preemption
// Optional alert blink enabled by defining SEG_SCHED_BLINK_EN.
module seg_display_scheduler
    import seg_pkg::*;
#(
    parameter int NUM_SRC      = 4,
    parameter int DWELL_CYCLES = 100000000,
    parameter int ALERT_CYCLES = 200000000,
    parameter int BLINK_CYCLES = 25000000,
    parameter int CNT_W        = 28
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_SRC-1:0]     src_valid,
    input  logic [16*NUM_SRC-1:0]  src_nums,
    input  logic                   alert_req,
    input  logic [15:0]            alert_nums,
    output logic                   alert_ack,
    output logic [15:0]            nums,
    output logic [2:0]             active_src,
    output logic                   alert_active
);

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] ALERT_LAST = CNT_W'(ALERT_CYCLES - 1);

    seg_state_t        r_state;
    logic [15:0]       r_nums;
    logic [15:0]       r_alert_code;
    logic [2:0]        r_active_src;
    logic              r_alert_ack;
    logic              r_alert_active;
    logic [CNT_W-1:0]  r_dwell_cnt;
    logic [CNT_W-1:0]  r_alert_cnt;

    logic [2:0]        w_next_src;
    logic              w_any_valid;
    logic              w_cur_valid;
    logic [15:0]       w_cur_nums;
    logic [15:0]       w_alert_view;

    seg_rr_pick #(
        .NUM_SRC (NUM_SRC)
    ) u_pick (
        .i_valid     (src_valid),
        .i_cur       (r_active_src),
        .o_next      (w_next_src),
        .o_any_valid (w_any_valid)
    );

    always_comb begin
        w_cur_nums  = src_nums[15:0];
        w_cur_valid = src_valid[0];
        for (int i = 1; i < NUM_SRC; i++) begin
            if (r_active_src == 3'(i)) begin
                w_cur_nums  = src_nums[16*i +: 16];
                w_cur_valid = src_valid[i];
            end
        end
    end

`ifdef SEG_SCHED_BLINK_EN
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_CYCLES - 1);

    logic [CNT_W-1:0]  r_blink_cnt;
    logic              r_blink_off;

    // Held clear outside ALERT so every alert starts on the visible phase.
    always_ff @(posedge clk) begin
        if (!rst || r_state != ALERT) begin
            r_blink_cnt <= '0;
            r_blink_off <= 1'b0;
        end else if (r_blink_cnt == BLINK_LAST) begin
            r_blink_cnt <= '0;
            r_blink_off <= ~r_blink_off;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    assign w_alert_view = r_blink_off ? SEG_BLANK : r_alert_code;
`else
    assign w_alert_view = r_alert_code;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= IDLE;
            r_nums         <= SEG_BLANK;
            r_alert_code   <= SEG_BLANK;
            r_active_src   <= 3'd0;
            r_alert_ack    <= 1'b0;
            r_alert_active <= 1'b0;
            r_dwell_cnt    <= '0;
            r_alert_cnt    <= '0;
        end else begin
            r_alert_ack    <= 1'b0;
            r_alert_active <= (r_state == ALERT);

            // Output follows the state one cycle behind, so nums and alert_active stay aligned.
            case (r_state)
                IDLE:    r_nums <= SEG_BLANK;
                SHOW:    r_nums <= w_cur_nums;
                default: r_nums <= w_alert_view;
            endcase

            if (r_state != ALERT && alert_req) begin
                r_alert_code <= alert_nums;
                r_alert_ack  <= 1'b1;
                r_alert_cnt  <= '0;
                r_state      <= ALERT;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_any_valid) begin
                            r_active_src <= w_next_src;
                            r_dwell_cnt  <= '0;
                            r_state      <= SHOW;
                        end
                    end
                    SHOW: begin
                        if (!w_any_valid) begin
                            r_dwell_cnt <= '0;
                            r_state     <= IDLE;
                        end else if (!w_cur_valid || r_dwell_cnt == DWELL_LAST) begin
                            r_active_src <= w_next_src;
                            r_dwell_cnt  <= '0;
                        end else begin
                            r_dwell_cnt <= r_dwell_cnt + 1'b1;
                        end
                    end
                    ALERT: begin
                        if (r_alert_cnt == ALERT_LAST) begin
                            r_alert_cnt <= '0;
                            r_dwell_cnt <= '0;
                            r_state     <= w_any_valid ? SHOW : IDLE;
                        end else begin
                            r_alert_cnt <= r_alert_cnt + 1'b1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign nums         = r_nums;
    assign active_src   = r_active_src;
    assign alert_ack    = r_alert_ack;
    assign alert_active = r_alert_active;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// tb/tb_seg_display_scheduler.sv - directed scenarios plus randomized run against a behavioural model
module tb_seg_display_scheduler;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AL = 12;
    localparam int BL = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    src_valid;
    logic [16*N-1:0] src_nums;
    logic            alert_req;
    logic [15:0]     alert_nums;
    logic            alert_ack;
    logic [15:0]     nums;
    logic [2:0]      active_src;
    logic            alert_active;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    seg_display_scheduler #(
        .NUM_SRC      (N),
        .DWELL_CYCLES (DW),
        .ALERT_CYCLES (AL),
        .BLINK_CYCLES (BL),
        .CNT_W        (28)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .src_valid    (src_valid),
        .src_nums     (src_nums),
        .alert_req    (alert_req),
        .alert_nums   (alert_nums),
        .alert_ack    (alert_ack),
        .nums         (nums),
        .active_src   (active_src),
        .alert_active (alert_active)
    );

    // Behavioural model: mode, shown source, and remaining-cycle countdowns.
    typedef enum int {M_IDLE, M_SHOW, M_ALERT} mmode_t;
    mmode_t      m_mode   = M_IDLE;
    int          m_sel    = 0;
    int          m_left   = 0;
    int          m_aleft  = 0;
    logic [15:0] m_code   = 16'hFFFF;
    logic [15:0] m_nums   = 16'hFFFF;
    logic        m_ack    = 1'b0;
    logic        m_aa     = 1'b0;

    function automatic logic [15:0] alert_view(int k, logic [15:0] code);
`ifdef SEG_SCHED_BLINK_EN
        return (((k / BL) % 2) == 1) ? 16'hFFFF : code;
`else
        return (k >= 0) ? code : 16'hFFFF;
`endif
    endfunction

    function automatic int next_valid(int cur, logic [N-1:0] v);
        logic [N-1:0] s;
        for (int k = 1; k <= N; k++) begin
            s = v >> ((cur + k) % N);
            if (s[0]) return (cur + k) % N;
        end
        return cur;
    endfunction

    function automatic logic [15:0] code_of(int s);
        logic [3:0] d;
        d = 4'(s + 1);
        return {d, d, d, d};
    endfunction

    task automatic model_step();
        logic [16*N-1:0] sh;
        logic [N-1:0]    vs;
        if (!rst) begin
            m_mode = M_IDLE; m_sel = 0; m_left = 0; m_aleft = 0;
            m_code = 16'hFFFF; m_nums = 16'hFFFF; m_ack = 1'b0; m_aa = 1'b0;
            return;
        end
        sh = src_nums >> (16 * m_sel);
        vs = src_valid >> m_sel;
        case (m_mode)
            M_IDLE:  m_nums = 16'hFFFF;
            M_SHOW:  m_nums = sh[15:0];
            default: m_nums = alert_view(AL - m_aleft, m_code);
        endcase
        m_aa  = (m_mode == M_ALERT);
        m_ack = 1'b0;
        if (m_mode != M_ALERT && alert_req) begin
            m_code = alert_nums; m_ack = 1'b1; m_mode = M_ALERT; m_aleft = AL;
        end else if (m_mode == M_IDLE) begin
            if (src_valid != 0) begin
                m_sel = next_valid(m_sel, src_valid); m_mode = M_SHOW; m_left = DW;
            end
        end else if (m_mode == M_SHOW) begin
            if (src_valid == 0) begin
                m_mode = M_IDLE;
            end else if (!vs[0]) begin
                m_sel = next_valid(m_sel, src_valid); m_left = DW;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_sel = next_valid(m_sel, src_valid); m_left = DW;
                end
            end
        end else begin
            m_aleft--;
            if (m_aleft == 0) begin
                m_mode = (src_valid != 0) ? M_SHOW : M_IDLE; m_left = DW;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0; src_valid = '0; alert_req = 1'b0; alert_nums = 16'h0000;
        repeat (2) tick();
        rst = 1'b1;
        src_nums = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    endtask

    task automatic test_reset();
        rst = 1'b0; src_valid = '1; alert_req = 1'b1; alert_nums = 16'h1234;
        src_nums = {$urandom, $urandom};
        repeat (3) tick();
        vectors++;
        if (nums !== 16'hFFFF) begin errors++; $display("FAIL reset_nums got %h exp ffff", nums); end
        vectors++;
        if (active_src !== 3'd0) begin errors++; $display("FAIL reset_src got %0d exp 0", active_src); end
        vectors++;
        if ({alert_ack, alert_active} !== 2'b00) begin
            errors++; $display("FAIL reset_alert got ack=%b act=%b exp 0 0", alert_ack, alert_active);
        end
        rst = 1'b1; src_valid = '0; alert_req = 1'b0;
        repeat (4) begin
            tick();
            vectors++;
            if ({nums, active_src} !== {16'hFFFF, 3'd0}) begin
                errors++; $display("FAIL idle_blank got %h/%0d exp ffff/0", nums, active_src);
            end
        end
    endtask

    task automatic test_rotation();
        int ord[4] = '{1, 3, 0, 1};
        logic [15:0] en;
        do_reset();
        src_valid = 4'b1011;
        for (int i = 0; i < 32; i++) begin
            tick();
            en = (i == 0) ? 16'hFFFF : code_of(ord[(i - 1) / 8]);
            vectors++;
            if ({active_src, nums} !== {3'(ord[i / 8]), en}) begin
                errors++;
                $display("FAIL rotation cyc %0d got %0d/%h exp %0d/%h", i, active_src, nums, ord[i / 8], en);
            end
        end
    endtask

    task automatic test_drop();
        do_reset();
        src_valid = 4'b1011;
        repeat (4) tick();
        src_valid = 4'b1001;
        tick();
        vectors++;
        if ({active_src, nums} !== {3'd3, 16'h2222}) begin
            errors++; $display("FAIL drop_switch got %0d/%h exp 3/2222", active_src, nums);
        end
        for (int i = 1; i <= 8; i++) begin
            tick();
            vectors++;
            if ({active_src, nums} !== {(i < 8) ? 3'd3 : 3'd0, 16'h4444}) begin
                errors++; $display("FAIL drop_hold cyc %0d got %0d/%h exp %0d/4444", i, active_src, nums, (i < 8) ? 3 : 0);
            end
        end
    endtask

    task automatic test_alert();
        logic [15:0] en;
        do_reset();
        src_valid = 4'b1011;
        repeat (14) tick();
        alert_req = 1'b1; alert_nums = 16'hB0CF;
        tick();
        alert_req = 1'b0;
        vectors++;
        if ({alert_ack, active_src, nums} !== {1'b1, 3'd3, 16'h4444}) begin
            errors++; $display("FAIL alert_accept got ack=%b %0d/%h exp ack=1 3/4444", alert_ack, active_src, nums);
        end
        for (int i = 1; i <= 20; i++) begin
            alert_req = (i == 5);
            alert_nums = 16'h7777;
            tick();
            alert_req = 1'b0;
            en = (i <= 12) ? alert_view(i - 1, 16'hB0CF) : 16'h4444;
            vectors++;
            if ({alert_ack, alert_active, active_src, nums} !== {1'b0, (i <= 12), (i < 20) ? 3'd3 : 3'd0, en}) begin
                errors++;
                $display("FAIL alert_run cyc %0d got ack=%b act=%b %0d/%h exp ack=0 act=%b %0d/%h",
                         i, alert_ack, alert_active, active_src, nums, (i <= 12), (i < 20) ? 3 : 0, en);
            end
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        src_valid = 4'b1011;
        repeat (8) tick();
        alert_req = 1'b1; alert_nums = 16'hA5A5;
        tick();
        alert_req = 1'b0;
        vectors++;
        if ({alert_ack, active_src} !== {1'b1, 3'd1}) begin
            errors++; $display("FAIL simul_accept got ack=%b src=%0d exp ack=1 src=1", alert_ack, active_src);
        end
        repeat (13) tick();
        vectors++;
        if ({alert_active, active_src, nums} !== {1'b0, 3'd1, 16'h2222}) begin
            errors++; $display("FAIL simul_resume got act=%b %0d/%h exp act=0 1/2222", alert_active, active_src, nums);
        end
        alert_req = 1'b1; alert_nums = 16'hC1BB;
        tick();
        alert_req = 1'b0; src_valid = '0;
        repeat (12) tick();
        vectors++;
        if ({alert_active, nums} !== {1'b1, alert_view(11, 16'hC1BB)}) begin
            errors++; $display("FAIL simul_last_alert got act=%b %h", alert_active, nums);
        end
        repeat (2) begin
            tick();
            vectors++;
            if ({alert_active, nums} !== {1'b0, 16'hFFFF}) begin
                errors++; $display("FAIL simul_idle got act=%b %h exp act=0 ffff", alert_active, nums);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        src_valid = 4'b0110;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) src_valid = N'($urandom);
            src_nums[16 * $urandom_range(0, N - 1) +: 16] = 16'($urandom);
            alert_req  = ($urandom_range(0, 24) == 0);
            alert_nums = 16'($urandom);
            rst        = ($urandom_range(0, 399) != 0);
            tick();
            vectors++;
            if ({nums, active_src, alert_ack, alert_active} !== {m_nums, 3'(m_sel), m_ack, m_aa}) begin
                errors++;
                $display("FAIL random cyc %0d got %h/%0d/%b/%b exp %h/%0d/%b/%b", i,
                         nums, active_src, alert_ack, alert_active, m_nums, m_sel, m_ack, m_aa);
            end
        end
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; src_valid = '0; src_nums = '0; alert_req = 1'b0; alert_nums = 16'h0000;
        @(negedge clk);
        test_reset();
        test_rotation();
        test_drop();
        test_alert();
        test_simultaneous();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/seg_display_scheduler.md
Name: seg_display_scheduler

Overview:
- Shares the single 4-digit 7-segment display between NUM_SRC requesters (score, timer, status, etc.) plus one high-priority alert channel.
- Produces the registered 16-bit nums bus ({BCD4,BCD3,BCD2,BCD1}) that feeds the existing display driver.
- Rotates among valid sources round-robin with a fixed dwell time.
- An alert preempts the rotation for a fixed duration, then the rotation resumes.

Parameters:
- NUM_SRC, 4, number of rotating requesters (2..8).
- DWELL_CYCLES, 100000000, clk cycles each source is shown (1 s at 100 MHz).
- ALERT_CYCLES, 200000000, clk cycles an accepted alert is shown.
- BLINK_CYCLES, 25000000, half-period of the alert blink (used only with the optional feature).
- CNT_W, 28, counter width; must hold the maximum of the above cycle counts.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low (0 = reset).
- src_valid  in  NUM_SRC  source i requests display time.
- src_nums  in  16*NUM_SRC  source i code at bits [16i+15:16i]; live value.
- alert_req  in  1  level request for an alert.
- alert_nums  in  16  alert code, sampled on acceptance.
- alert_ack  out  1  one-cycle pulse when the alert is accepted.
- nums  out  16  code to the display driver.
- active_src  out  3  index of the source currently shown.
- alert_active  out  1  high while the alert is shown.

Behaviour:
- Reset (rst==0 at posedge): state=IDLE, nums=16'hFFFF (blank), active_src=0, alert_active=0, alert_ack=0, counters=0.
- Digit codes: 0-9 digits, 10 'C', 11 '-', 15 blank.
- IDLE:
  - nums=16'hFFFF.
  - If any src_valid is set, select the first valid index at or above active_src+1, wrapping; go to SHOW; clear the dwell counter.
- SHOW:
  - nums <= src_nums[active_src] every cycle, so it tracks live updates with 1-cycle latency.
  - The dwell counter increments each cycle. At DWELL_CYCLES-1, pick the next valid source round-robin from active_src+1, wrapping, and restart the counter.
  - If the current source is the only valid one, stay on it and restart the counter.
- Current source drops src_valid mid-dwell: on the next edge, switch to the next valid source and restart the counter. If no source is valid, go to IDLE.
- No valid sources in SHOW: go to IDLE. nums becomes blank on the following edge.
- Alert acceptance:
  - Condition: alert_req==1 while in IDLE or SHOW.
  - Actions: latch alert_nums, pulse alert_ack for 1 cycle, go to ALERT, clear the alert counter, and freeze active_src.
  - The alert beats a same-cycle dwell expiry; the expiry is discarded.
- ALERT:
  - nums=latched alert code; alert_active=1.
  - alert_req is ignored (no ack) while in ALERT.
  - At ALERT_CYCLES-1, return to SHOW on the same active_src with the dwell counter cleared, or to IDLE if no source is valid.
  - A valid change to active_src during ALERT is resolved on the first cycle back in SHOW, using the rule above.
- Latency: state or selection change to new nums value is exactly 1 cycle.
- Counters saturate nowhere: they are explicitly cleared on every state or selection change.
- Reset asserted mid-dwell or mid-alert: the next edge returns everything to reset values; no ack is issued.

Optional Feature:
- Macro: SEG_SCHED_BLINK_EN.
- Defined: in ALERT, nums alternates between the alert code and 16'hFFFF every BLINK_CYCLES, starting with the alert code. A blink counter is cleared on entry to ALERT.
- Undefined: the alert code is shown steadily; there is no blink counter or BLINK_CYCLES logic.

Decomposition:
- Shared package seg_pkg:
  - SEG_BLANK=16'hFFFF.
  - Digit code constants: SEG_C=4'd10, SEG_DASH=4'd11, SEG_OFF=4'd15.
  - State enum: IDLE, SHOW, ALERT.
- One sub-module, seg_rr_pick: combinational round-robin next-index finder.
  - Inputs: valid vector and current index.
  - Outputs: next index and any_valid.
  - Reused for both dwell rotation and dropped-source handling.

Test Plan (NUM_SRC=4, DWELL_CYCLES=8, ALERT_CYCLES=12, BLINK_CYCLES=3):
- Reset: hold rst=0 for 3 cycles with all inputs active -> nums=16'hFFFF, active_src=0, alert_ack=0; release with src_valid=0 -> remains IDLE and blank.
- Rotation: src_valid=4'b1011, src_nums per source distinct (0x1111, 0x2222, -, 0x4444) -> shows src1 for 8 cycles, then src3 for 8, then src0 for 8, then src1 again; src2 never shown.
- Drop mid-dwell: on src1, deassert src_valid[1] at cycle 3 -> the next edge selects src3 and the dwell counter restarts (src3 held 8 full cycles).
- Alert preempt: on src3 at dwell cycle 5, raise alert_req with alert_nums=16'hB0CF -> alert_ack is a single pulse; nums=16'hB0CF for 12 cycles; a second alert_req during ALERT gets no ack; then src3 resumes for 8 cycles.
- Simultaneous events: alert_req on the same cycle as dwell expiry -> the alert wins; after ALERT the original active_src is shown. Also all src_valid dropping during ALERT -> IDLE and blank after ALERT.
- Blink (with SEG_SCHED_BLINK_EN): during ALERT, nums follows the pattern alert×3, blank×3, alert×3, blank×3. Without the macro, nums is steady alert for 12 cycles.
